// File: rtl/add_sequencer_pkg.sv
// Shared constants for the add sequencer: default operand width, synchronizer
// depth and the 2-bit FSM encoding that is also shown on the state LEDs.
package add_sequencer_pkg;

  localparam int unsigned ADD_WIDTH  = 3;
  localparam int unsigned SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_A = 2'b01,
    CALC  = 2'b10,
    SHOW  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/btn_step_sync.sv
// Synchronizes the raw push-button and turns each press into a single-cycle
// registered step pulse, lagging the button edge by SYNC_STAGES+1 cycles.
module btn_step_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   prev_q, prev_d;
  logic                   arm_q, arm_d;
  logic                   step_q, step_d;
  logic                   btn_sync;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    sync_d = (sync_q << 1) | SYNC_STAGES'(btn);
    fill_d = (fill_q << 1) | SYNC_STAGES'(1'b1);
    prev_d = btn_sync;
    // Arm only once a real, fully synchronized low has been seen after reset,
    // so a button held through reset release never produces a step.
    arm_d  = arm_q | (fill_q[SYNC_STAGES-1] & ~btn_sync);
    step_d = arm_q & btn_sync & ~prev_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fill_q <= fill_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/add_sequencer.sv
// Steps two switch operands into an external adder on button presses and
// captures the full sum (carry included) for display.
module add_sequencer
  import add_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = ADD_WIDTH,
  parameter int unsigned SYNC_STAGES = SYNC_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             btn,
  input  logic             clr,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] sum_s,
  input  logic             sum_cout,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic             done,
  output logic [1:0]       state
);

  logic step;

  btn_step_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .step (step)
  );

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (step) state_d = GOT_A;
        GOT_A:   if (step) state_d = CALC;
        CALC:    state_d = SHOW;
        SHOW:    if (step) state_d = GOT_A;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next-state; a step arriving in CALC falls through untouched.
  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (clr) begin
      op_a_d   = '0;
      op_b_d   = '0;
      result_d = '0;
    end else begin
      case (state_q)
        IDLE, SHOW: if (step) op_a_d = data_in;
        GOT_A:      if (step) op_b_d = data_in;
        CALC: begin
          result_d = {sum_cout, sum_s};
          done_d   = 1'b1;
        end
        default: ;
      endcase
    end
    valid_d = (state_d == SHOW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign done         = done_q;
  assign state        = state_q;

endmodule

// File: tb/tb_add_sequencer.sv
// Bench for add_sequencer: models the external adder and predicts outputs from
// the sequence of accepted presses, clears and resets.
module tb_add_sequencer;

  localparam int W = 3;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n, btn, clr;
  logic [W-1:0] data_in, op_a, op_b, sum_s;
  logic         sum_cout;
  logic [W:0]   result;
  logic         result_valid, done;
  logic [1:0]   state;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int calc_cnt = 0;

  // Transaction-level model: phase 0 = nothing loaded, 1 = A loaded, 2 = sum shown.
  int           m_phase = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W:0]   m_res = '0;
  int           m_sums = 0;

  always #5 clk = ~clk;

  assign {sum_cout, sum_s} = {1'b0, op_a} + {1'b0, op_b};

  add_sequencer #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .btn         (btn),
    .clr         (clr),
    .op_a        (op_a),
    .op_b        (op_b),
    .sum_s       (sum_s),
    .sum_cout    (sum_cout),
    .result      (result),
    .result_valid(result_valid),
    .done        (done),
    .state       (state)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (state === 2'b10) calc_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] phase_state(int ph);
    case (ph)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic void model_step(logic [W-1:0] v);
    case (m_phase)
      0: begin m_a = v; m_phase = 1; end
      1: begin
        m_b     = v;
        m_res   = {1'b0, m_a} + {1'b0, v};
        m_phase = 2;
        m_sums++;
      end
      default: begin m_a = v; m_phase = 1; end
    endcase
  endfunction

  function automatic void model_clear();
    m_phase = 0;
    m_a     = '0;
    m_b     = '0;
    m_res   = '0;
  endfunction

  task automatic press(input logic [W-1:0] v, input int hold);
    @(negedge clk);
    data_in = v;
    btn     = 1'b1;
    repeat (hold) @(negedge clk);
    btn     = 1'b0;
    data_in = W'($urandom);
    repeat (S + 4) @(negedge clk);
    model_step(v);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = 1'b0; clr = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", state); end
    n_tests++;
    if ({op_a, op_b} !== '0) begin n_fail++; $display("FAIL reset_ops: got a=%0d b=%0d want 0 0", op_a, op_b); end
    n_tests++;
    if ({result, result_valid, done} !== '0) begin
      n_fail++; $display("FAIL reset_result: got res=%b valid=%b done=%b want 0", result, result_valid, done);
    end
    rst_n = 1'b1;
    repeat (S + 3) @(negedge clk);
  endtask

  task automatic test_latency();
    int cycles = 0;
    @(negedge clk);
    data_in = 3'd4;
    btn     = 1'b1;
    while (state === 2'b00 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    n_tests++;
    if (cycles !== S + 2) begin n_fail++; $display("FAIL step_latency: got %0d cycles want %0d", cycles, S + 2); end
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (S + 4) @(negedge clk);
    model_step(3'd4);
    n_tests++;
    if (op_a !== m_a) begin n_fail++; $display("FAIL latency_op_a: got %0d want %0d", op_a, m_a); end
    do_clr();
    n_tests++;
    if (state !== 2'b00 || op_a !== '0) begin
      n_fail++; $display("FAIL clr_idle: got state=%b a=%0d want 00 0", state, op_a);
    end
  endtask

  task automatic test_basic_sum();
    int d0 = done_cnt;
    int c0 = calc_cnt;
    press(3'd3, 6);
    press(3'd2, 6);
    n_tests++;
    if (result !== 4'b0101) begin n_fail++; $display("FAIL basic_result: got %b want 0101", result); end
    n_tests++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0); end
    n_tests++;
    if (calc_cnt - c0 !== 1) begin n_fail++; $display("FAIL basic_calc: got %0d CALC cycles want 1", calc_cnt - c0); end
    n_tests++;
    if (state !== 2'b11 || result_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_show: got state=%b valid=%b want 11 1", state, result_valid);
    end
    n_tests++;
    if (op_a !== 3'd3 || op_b !== 3'd2) begin
      n_fail++; $display("FAIL basic_ops: got a=%0d b=%0d want 3 2", op_a, op_b);
    end
  endtask

  task automatic test_carry();
    press(3'd7, 7);
    n_tests++;
    if (state !== 2'b01 || result_valid !== 1'b0) begin
      n_fail++; $display("FAIL show_restart: got state=%b valid=%b want 01 0", state, result_valid);
    end
    press(3'd7, 7);
    n_tests++;
    if (result !== 4'b1110) begin n_fail++; $display("FAIL carry_result: got %b want 1110", result); end
    press(3'd1, 5);
    press(3'd0, 5);
    n_tests++;
    if (result !== 4'b0001 || result_valid !== 1'b1) begin
      n_fail++; $display("FAIL stale_carry: got %b valid=%b want 0001 1", result, result_valid);
    end
  endtask

  task automatic test_hold();
    do_clr();
    @(negedge clk);
    data_in = 3'd6;
    btn     = 1'b1;
    repeat (S + 4) @(negedge clk);
    data_in = 3'd1;
    repeat (50 - (S + 4)) @(negedge clk);
    btn     = 1'b0;
    data_in = 3'd2;
    repeat (S + 4) @(negedge clk);
    model_step(3'd6);
    n_tests++;
    if (state !== 2'b01) begin n_fail++; $display("FAIL hold_state: got %b want 01", state); end
    n_tests++;
    if (op_a !== 3'd6 || op_b !== 3'd0) begin
      n_fail++; $display("FAIL hold_ops: got a=%0d b=%0d want 6 0", op_a, op_b);
    end
  endtask

  task automatic test_reset_mid();
    do_clr();
    press(3'd5, 6);
    n_tests++;
    if (state !== 2'b01 || op_a !== 3'd5) begin
      n_fail++; $display("FAIL pre_reset: got state=%b a=%0d want 01 5", state, op_a);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    n_tests++;
    if (state !== 2'b00 || {op_a, op_b, result, result_valid, done} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got state=%b a=%0d b=%0d res=%b valid=%b done=%b want all 0",
               state, op_a, op_b, result, result_valid, done);
    end
    repeat (S + 3) @(negedge clk);
    // Button held across reset release must stay silent until re-pressed.
    @(negedge clk);
    data_in = 3'd3;
    btn     = 1'b1;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (state !== 2'b00 || op_a !== 3'd0) begin
      n_fail++; $display("FAIL held_through_reset: got state=%b a=%0d want 00 0", state, op_a);
    end
    btn = 1'b0;
    repeat (S + 4) @(negedge clk);
    press(3'd3, 6);
    n_tests++;
    if (state !== 2'b01 || op_a !== m_a) begin
      n_fail++; $display("FAIL repress_after_reset: got state=%b a=%0d want 01 %0d", state, op_a, m_a);
    end
  endtask

  task automatic test_clr_step();
    press(3'd4, 6);
    n_tests++;
    if (state !== 2'b11 || result !== 4'b0111) begin
      n_fail++; $display("FAIL pre_clr_show: got state=%b res=%b want 11 0111", state, result);
    end
    @(negedge clk);
    data_in = 3'd6;
    btn     = 1'b1;
    repeat (S + 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (S + 4) @(negedge clk);
    model_clear();
    n_tests++;
    if (state !== 2'b00 || result !== '0 || result_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_step_state: got state=%b res=%b valid=%b want 00 0 0", state, result, result_valid);
    end
    n_tests++;
    if (op_a !== 3'd0 || op_b !== 3'd0) begin
      n_fail++; $display("FAIL clr_step_ops: got a=%0d b=%0d want 0 0", op_a, op_b);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int gap;
      gap = $urandom_range(0, 6);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        data_in = W'($urandom);
      end
      if ($urandom_range(0, 7) == 0) do_clr();
      else press(W'($urandom), S + 3 + int'($urandom_range(0, 4)));
      n_tests++;
      if (state !== phase_state(m_phase)) begin
        n_fail++; $display("FAIL rand_state[%0d]: got %b want %b", it, state, phase_state(m_phase));
      end
      n_tests++;
      if (op_a !== m_a || op_b !== m_b) begin
        n_fail++; $display("FAIL rand_ops[%0d]: got a=%0d b=%0d want %0d %0d", it, op_a, op_b, m_a, m_b);
      end
      n_tests++;
      if (result !== m_res || result_valid !== (m_phase == 2)) begin
        n_fail++; $display("FAIL rand_result[%0d]: got %b valid=%b want %b %b", it, result, result_valid,
                           m_res, (m_phase == 2));
      end
    end
    n_tests++;
    if (done_cnt !== m_sums || calc_cnt !== m_sums) begin
      n_fail++; $display("FAIL rand_done_count: got done=%0d calc=%0d want %0d", done_cnt, calc_cnt, m_sums);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic_sum();
    test_carry();
    test_hold();
    test_reset_mid();
    test_clr_step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/add_sequencer.md
ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the operand width (matches the 3-bit adder).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for btn.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 The block SHALL have port data_in, input, WIDTH, the operand value from the switches.
REQ-006 The block SHALL have port btn, input, 1, the raw asynchronous push-button "step" request.
REQ-007 The block SHALL have port clr, input, 1, a synchronous clear, active-high.
REQ-008 The block SHALL have port op_a, output, WIDTH, a registered operand A driven to the adder A input.
REQ-009 The block SHALL have port op_b, output, WIDTH, a registered operand B driven to the adder B input.
REQ-010 The block SHALL have port sum_s, input, WIDTH, the adder sum S (combinational from op_a/op_b).
REQ-011 The block SHALL have port sum_cout, input, 1, the adder carry out.
REQ-012 The block SHALL have port result, output, WIDTH+1, the registered {sum_cout, sum_s}.
REQ-013 The block SHALL have port result_valid, output, 1, high while result holds a completed sum.
REQ-014 The block SHALL have port done, output, 1, a one-cycle pulse when result is captured.
REQ-015 The block SHALL have port state, output, 2, the current FSM state for LEDs.

Function
REQ-016 btn SHALL pass through SYNC_STAGES flip-flops, then a rising-edge detector producing step, one cycle wide per press regardless of hold length.
REQ-017 step SHALL lag the btn rising edge by SYNC_STAGES+1 cycles.
REQ-018 The FSM SHALL have states IDLE=00, GOT_A=01, CALC=10, SHOW=11.
REQ-019 In IDLE, step SHALL load op_a<=data_in and move to GOT_A; otherwise the FSM SHALL hold.
REQ-020 In GOT_A, step SHALL load op_b<=data_in and move to CALC; otherwise the FSM SHALL hold.
REQ-021 CALC SHALL last exactly one cycle: result<={sum_cout,sum_s}, done=1 on the following cycle, then move to SHOW.
REQ-022 In SHOW, result_valid SHALL be 1 and op_a, op_b and result SHALL be held.
REQ-023 In SHOW, step SHALL load op_a<=data_in, clear result_valid and move to GOT_A, starting a new sum.
REQ-024 result SHALL be the full unsigned sum of op_a and op_b; no overflow is lost because result[WIDTH] is the carry.
REQ-025 data_in SHALL be sampled only on the step cycle; changes at other times SHALL have no effect.
REQ-026 clr SHALL take priority over step; when both occur in the same cycle, clr wins and that step is discarded.
REQ-027 clr SHALL force IDLE and zero op_a, op_b, result, result_valid and done on the next edge.
REQ-028 A step arriving while in CALC SHALL be ignored (CALC is never extended).
REQ-029 state SHALL equal the registered FSM encoding, with no combinational decode.

Reset
REQ-030 On rst_n=0 at a clk edge, all of the following SHALL apply: FSM=IDLE, op_a=0, op_b=0, result=0, result_valid=0, done=0, synchronizer and edge registers=0.
REQ-031 Reset SHALL take priority over clr and step, including mid-operation in any state.
REQ-032 A button held through reset release SHALL NOT generate a step until it is released and pressed again.

Structure
REQ-033 A shared package SHALL hold the WIDTH default constant and the 2-bit state encoding constants (IDLE, GOT_A, CALC, SHOW).
REQ-034 The synchronizer plus edge detector SHALL be one sub-module, btn_step_sync (ports clk, rst_n, btn, step).
REQ-035 The adder SHALL NOT be instantiated inside add_sequencer; the top level SHALL connect op_a/op_b and sum_s/sum_cout to the existing 3-bit adder.

Verification
REQ-036 The bench SHALL cover: data_in=3 press, data_in=2 press -> result=4'b0101, done pulses once, state=11, result_valid=1.
REQ-037 The bench SHALL cover: 7 then 7 -> result=4'b1110 (carry=1); then 1 then 0 -> result=4'b0001 with no stale carry.
REQ-038 The bench SHALL cover: btn held 50 cycles in IDLE -> exactly one step, op_a loaded once, state=01.
REQ-039 The bench SHALL cover: rst_n=0 for 1 cycle while in GOT_A with op_a=5 -> next cycle state=00, op_a=0, all outputs 0.
REQ-040 The bench SHALL cover: clr and step coincident in SHOW -> state=00, result=0, op_a unchanged from data_in (i.e. 0).
REQ-041 The bench SHALL cover: data_in toggled between presses -> only values present on step cycles appear in op_a/op_b.
